// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states,
// default operand width and small op-classification helpers.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_REM   = 3'd5,
    OP_REMU  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_mul(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU};
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Ops whose operands are interpreted as two's-complement (MUL low half is sign-agnostic).
  function automatic logic op_is_signed(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: used for operand magnitudes and result sign fix-up.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide: radix-2 shift-add multiply, restoring divide,
// XLEN iterations per op. Optional MULDIV_EARLY_OUT_EN bypasses the loop for zero operands.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_e            r_state;
  op_e               r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_count;
  logic              r_neg_q;
  logic              r_neg_r;

  op_e               w_op;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_early;
  logic              w_special;
  logic [2*XLEN-1:0] w_acc_init;

  assign w_op    = op_e'(op);
  assign w_neg_a = op_is_signed(w_op) & rs1[XLEN-1];
  assign w_neg_b = op_is_signed(w_op) & rs2[XLEN-1];

  muldiv_abs #(.W(XLEN)) u_abs_a (.i_neg(w_neg_a), .i_val(rs1), .o_val(w_mag_a));
  muldiv_abs #(.W(XLEN)) u_abs_b (.i_neg(w_neg_b), .i_val(rs2), .o_val(w_mag_b));

  assign w_div_zero = op_is_div(w_op) && (rs2 == '0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (op_is_mul(w_op) && ((rs1 == '0) || (rs2 == '0))) ||
                   (op_is_div(w_op) && (rs1 == '0) && (rs2 != '0));
`else
  assign w_early = 1'b0;
`endif

  assign w_special = w_div_zero || w_ovf || w_early || (w_op == OP_RSVD);

  // Special cases preload the accumulator so FIX's normal select yields the fixed answer:
  // high half is read as remainder, low half as quotient.
  always_comb begin
    w_acc_init = {{XLEN{1'b0}}, w_mag_a};
    if ((w_op == OP_RSVD) || w_early) begin
      w_acc_init = '0;
    end else if (w_div_zero) begin
      w_acc_init = {rs1, {XLEN{1'b1}}};
    end else if (w_ovf) begin
      w_acc_init = {{XLEN{1'b0}}, rs1};
    end
  end

  // Multiply step: conditional add into the high half, then shift the whole accumulator right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: shift in the next dividend bit, subtract divisor when it fits.
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift[XLEN-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                           : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] w_fix_prod;
  logic [XLEN-1:0]   w_fix_q;
  logic [XLEN-1:0]   w_fix_r;
  logic [XLEN-1:0]   w_fix_result;

  muldiv_abs #(.W(2*XLEN)) u_fix_prod (.i_neg(r_neg_q), .i_val(r_acc), .o_val(w_fix_prod));
  muldiv_abs #(.W(XLEN)) u_fix_q (.i_neg(r_neg_q), .i_val(r_acc[XLEN-1:0]), .o_val(w_fix_q));
  muldiv_abs #(.W(XLEN)) u_fix_r (.i_neg(r_neg_r), .i_val(r_acc[2*XLEN-1:XLEN]), .o_val(w_fix_r));

  always_comb begin
    w_fix_result = '0;
    case (r_op)
      OP_MUL:                  w_fix_result = w_fix_prod[XLEN-1:0];
      OP_MULH, OP_MULHU:       w_fix_result = w_fix_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:         w_fix_result = w_fix_q;
      OP_REM, OP_REMU:         w_fix_result = w_fix_r;
      default:                 w_fix_result = '0;
    endcase
  end

  // busy/done are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      busy <= (r_state != IDLE);
      done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= w_op;
            r_acc   <= w_acc_init;
            r_b     <= w_mag_b;
            r_count <= '0;
            r_neg_q <= (w_neg_a ^ w_neg_b) & ~w_special;
            r_neg_r <= w_neg_a & ~w_special;
            r_state <= w_special ? FIX : CALC;
          end
        end
        CALC: begin
          r_acc   <= op_is_mul(r_op) ? w_mul_next : w_div_next;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(XLEN-1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          result  <= w_fix_result;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model, literal pins, random ops.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] pu;
    longint      ps;
    int          sa;
    int          sb;
    bit          ovf;
    sa  = a;
    sb  = b;
    pu  = {32'b0, a} * {32'b0, b};
    ps  = longint'(sa) * longint'(sb);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: return pu[31:0];
      3'd1: return ps[63:32];
      3'd2: return pu[63:32];
      3'd3: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd5: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      3'd6: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    bit sp;
    is_div = (o >= 3'd3) && (o <= 3'd6);
    sp = (o == 3'd7) || (is_div && (b == 0)) ||
         (((o == 3'd3) || (o == 3'd5)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
`ifdef MULDIV_EARLY_OUT_EN
    sp = sp || ((o <= 3'd2) && ((a == 0) || (b == 0))) || (is_div && (a == 0) && (b != 0));
`endif
    return sp ? 2 : 34;
  endfunction

  // Reference model: edges after acceptance are counted; busy spans edges 1..lat, done at lat.
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   <= 1'b0;
      m_cnt      <= 0;
      exp_busy   <= 1'b0;
      exp_done   <= 1'b0;
      exp_result <= '0;
    end else if (m_active) begin
      m_cnt    <= m_cnt + 1;
      exp_busy <= 1'b1;
      exp_done <= (m_cnt + 1 == m_lat);
      if (m_cnt + 1 == m_lat) begin
        exp_result <= m_res;
        m_active   <= 1'b0;
      end
    end else begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      if (start) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_lat    <= ref_lat(op, rs1, rs2);
        m_res    <= ref_result(op, rs1, rs2);
        m_op     <= op;
        m_a      <= rs1;
        m_b      <= rs2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (!exp_busy || exp_done) chk("result", result, exp_result);
      if (exp_done)
        $display("txn op=%0d a=%h b=%h lat=%0d exp=%h dut=%h", m_op, m_a, m_b, m_lat, exp_result, result);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while ((m_active || exp_busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  task automatic run_lit(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want, input int want_lat);
    int lat = 0;
    issue(o, a, b);
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk(name, result, want);
    chk({name, "_lat"}, 32'(lat), 32'(want_lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int early_lat;
`ifdef MULDIV_EARLY_OUT_EN
    early_lat = 2;
`else
    early_lat = 34;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_lit("mul_7_m3",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_lit("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_lit("mulhu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_lit("div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_lit("rem_m7_2",    3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_lit("divu_100_7",  3'd4, 32'd100, 32'd7, 32'd14, 34);
    run_lit("remu_100_7",  3'd6, 32'd100, 32'd7, 32'd2, 34);
    run_lit("div_by0",     3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_lit("rem_by0",     3'd5, 32'd5, 32'd0, 32'd5, 2);
    run_lit("div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_lit("rem_ovf",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    run_lit("rsvd",        3'd7, 32'h1234_5678, 32'd3, 32'd0, 2);
    run_lit("mul_0_9",     3'd0, 32'd0, 32'd9, 32'd0, early_lat);

    // A start pulse while busy must be ignored.
    issue(3'd4, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    rs1   = 32'd3;
    rs2   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat   = 6;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_start", result, 32'd14);
    chk("ign_start_lat", 32'(lat), 32'd34);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    issue(3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
